// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
package imem_fetch_pkg;

    localparam int DEPTH_DEFAULT = 2;
    localparam int AW_DEFAULT    = 32;
    localparam int DW_DEFAULT    = 32;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [DW_DEFAULT-1:0] data;
    } imem_resp_t;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Response FIFO: DEPTH x DW storage with push/pop/flush, occupancy count, head data.
// Latency: 1 cycle push -> head visible; head data is read straight from storage.
// Backpressure: none internally; the caller must never push when full unless popping.
//
// Ports: clk/rst (sync active-high), push/push_data, pop, flush (empties next cycle,
// overrides push/pop), count (0..DEPTH), head_data (valid when count != 0).
module imem_fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DW-1:0]                 push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [DW-1:0]                 head_data
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_buffer.sv
// Fetch buffer between F stage and variable-latency imem: credit-limited requests, in-order response FIFO, squash discard.
// Latency: request passes through combinationally; response reaches proc 1 cycle after mem (0 cycles with bypass).
// Backpressure: proc_req_rdy drops when inflight+buffered reaches DEPTH, on mem stall or squash; mem responses never stalled.
//
// Ports: clk/rst (sync active-high); proc_req_* fetch PC in; proc_resp_* instruction out;
// squash drops all outstanding/buffered fetches; mem_req_* to memory; mem_resp_* from memory.
// Build option: define IMEM_FETCH_BYPASS_EN to forward a response straight to the
// processor in the same cycle when nothing is buffered and nothing is being dropped.
module imem_fetch_buffer
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          proc_req_val,
    output logic          proc_req_rdy,
    input  logic [AW-1:0] proc_req_addr,
    output logic          proc_resp_val,
    input  logic          proc_resp_rdy,
    output logic [DW-1:0] proc_resp_data,
    input  logic          squash,
    output logic          mem_req_val,
    input  logic          mem_req_rdy,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_resp_val,
    input  logic [DW-1:0] mem_resp_data
);

    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [DW-1:0] head_data;
    logic [CW:0]   outstanding;
    logic          credit;
    logic          fire;
    logic          resp_keep;
    logic          fifo_push;
    logic          fifo_pop;

    // One extra bit so inflight+count never wraps before the compare.
    assign outstanding  = {1'b0, inflight} + {1'b0, count};
    assign credit       = outstanding < (CW+1)'(DEPTH);

    assign mem_req_val  = proc_req_val & credit & ~squash;
    assign mem_req_addr = proc_req_addr;
    assign proc_req_rdy = credit & mem_req_rdy & ~squash;
    assign fire         = proc_req_val & proc_req_rdy;

    // A response is kept only if it belongs to a live fetch: not owed to an earlier
    // squash, and not arriving in the squash cycle itself.
    assign resp_keep    = mem_resp_val & ~squash & (drop == '0);
    assign fifo_pop     = (count != '0) & proc_resp_rdy;

`ifdef IMEM_FETCH_BYPASS_EN
    logic bypass_vld;
    assign bypass_vld     = resp_keep & (count == '0);
    assign proc_resp_val  = (count != '0) | bypass_vld;
    assign proc_resp_data = (count != '0) ? head_data : mem_resp_data;
    // A bypassed response that the processor takes now must not also be buffered.
    assign fifo_push      = resp_keep & ~(bypass_vld & proc_resp_rdy);
`else
    assign proc_resp_val  = (count != '0);
    assign proc_resp_data = head_data;
    assign fifo_push      = resp_keep;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            case ({fire, mem_resp_val})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            // inflight already includes anything an earlier squash is still dropping,
            // so on a new squash every remaining in-flight response becomes a drop.
            if (squash) begin
                drop <= inflight - CW'(mem_resp_val);
            end else if (mem_resp_val && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    imem_fetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_resp_data),
        .pop       (fifo_pop),
        .flush     (squash),
        .count     (count),
        .head_data (head_data)
    );

`ifndef SYNTHESIS
    // Memory must never answer a fetch that was not issued.
    always_ff @(posedge clk) begin
        if (!rst && mem_resp_val) begin
            assert (inflight != '0) else $error("imem_fetch_buffer: mem response with nothing in flight");
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Self-checking bench for imem_fetch_buffer with a latency-3 in-order memory model and scoreboard.
// Latency: checks 1-cycle response path (0-cycle when IMEM_FETCH_BYPASS_EN is defined).
// Backpressure: exercises credit stall, processor hold, squash discard and random consumer stalls.
module tb_imem_fetch_buffer;
    import imem_fetch_pkg::*;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        proc_req_val;
    logic        proc_req_rdy;
    logic [31:0] proc_req_addr;
    logic        proc_resp_val;
    logic        proc_resp_rdy;
    logic [31:0] proc_resp_data;
    logic        squash;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [31:0] mem_req_addr;
    logic        mem_resp_val;
    logic [31:0] mem_resp_data;

    imem_fetch_buffer #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .proc_req_val   (proc_req_val),
        .proc_req_rdy   (proc_req_rdy),
        .proc_req_addr  (proc_req_addr),
        .proc_resp_val  (proc_resp_val),
        .proc_resp_rdy  (proc_resp_rdy),
        .proc_resp_data (proc_resp_data),
        .squash         (squash),
        .mem_req_val    (mem_req_val),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_val   (mem_resp_val),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    imem_resp_t  expq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          resp_cnt = 0;
    bit          mem_auto = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0200: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Sample at the falling edge, advance one clock, then drive the memory model.
    task automatic tick();
        imem_resp_t e;
        @(negedge clk);
        if (!rst) begin
            if (proc_req_val && proc_req_rdy) begin
                memq.push_back('{data: memdata(proc_req_addr), due: cyc + LAT});
                e.data = memdata(proc_req_addr);
                expq.push_back(e);
            end
            if (proc_resp_val && proc_resp_rdy) begin
                if (expq.size() == 0) begin
                    check("resp_extra", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    check("resp_data", proc_resp_data, e.data);
                end
                resp_cnt++;
            end
            if (mem_resp_val && memq.size() > 0) begin
                void'(memq.pop_front());
            end
            if (squash) begin
                expq.delete();
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mem_auto) begin
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                mem_resp_val  = 1'b1;
                mem_resp_data = memq[0].data;
            end else begin
                mem_resp_val  = 1'b0;
                mem_resp_data = '0;
            end
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        proc_req_val  = 1'b1;
        proc_req_addr = a;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (proc_req_rdy) break;
            tick();
        end
        check("req_rdy", proc_req_rdy, 1'b1);
        tick();
        proc_req_val = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (expq.size() == 0 && memq.size() == 0) break;
            tick();
        end
        check("drain_exp", 32'(expq.size()), 32'd0);
        check("drain_mem", 32'(memq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent;
        rst           = 1'b1;
        proc_req_val  = 1'b0;
        proc_req_addr = '0;
        proc_resp_rdy = 1'b0;
        squash        = 1'b0;
        mem_req_rdy   = 1'b1;
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // 1: reset / idle
        check("rst_resp_val", proc_resp_val, 1'b0);
        check("rst_mem_req_val", mem_req_val, 1'b0);
        check("rst_req_rdy", proc_req_rdy, 1'b1);
        tick();

        // 2: two fetches, third stalled by credit while both are outstanding/buffered
        base = resp_cnt;
        proc_resp_rdy = 1'b0;
        fetch(32'h0);
        fetch(32'h4);
        proc_req_val  = 1'b1;
        proc_req_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_rdy", proc_req_rdy, 1'b0);
            check("stall_mreq", mem_req_val, 1'b0);
            tick();
        end
        // 3: head held stable while the processor stalls
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_val", proc_resp_val, 1'b1);
            check("hold_data", proc_resp_data, 32'h0000_0013);
            check("hold_mreq", mem_req_val, 1'b0);
            tick();
        end
        proc_resp_rdy = 1'b1;
        #1;
        tick();
        fetch(32'h8);
        drain();
        check("t2_resp_cnt", 32'(resp_cnt - base), 32'd3);

        // 4: squash with two in flight; only the post-redirect fetch is delivered
        base = resp_cnt;
        fetch(32'h20);
        fetch(32'h24);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        #1;
        check("sq_resp_val", proc_resp_val, 1'b0);
        check("sq_drop", 32'(dut.drop), 32'd2);
        fetch(32'h100);
        drain();
        check("t4_resp_cnt", 32'(resp_cnt - base), 32'd1);

        // 5: squash coincides with the only in-flight response
        base = resp_cnt;
        mem_auto = 1'b0;
        fetch(32'h40);
        tick();
        mem_resp_val  = 1'b1;
        mem_resp_data = memdata(32'h40);
        squash        = 1'b1;
        tick();
        mem_resp_val  = 1'b0;
        squash        = 1'b0;
        #1;
        check("sq5_drop", 32'(dut.drop), 32'd0);
        check("sq5_inflight", 32'(dut.inflight), 32'd0);
        check("sq5_resp_val", proc_resp_val, 1'b0);
        mem_auto = 1'b1;
        fetch(32'h140);
        drain();
        check("t5_resp_cnt", 32'(resp_cnt - base), 32'd1);

        // 6: response into an empty FIFO with the processor ready
        base = resp_cnt;
        mem_auto = 1'b0;
        fetch(32'h200);
        tick();
        mem_resp_val  = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        #1;
`ifdef IMEM_FETCH_BYPASS_EN
        check("byp_val", proc_resp_val, 1'b1);
        check("byp_data", proc_resp_data, 32'hDEAD_BEEF);
`else
        check("byp_val", proc_resp_val, 1'b0);
`endif
        tick();
        mem_resp_val = 1'b0;
        #1;
`ifdef IMEM_FETCH_BYPASS_EN
        check("byp_next_val", proc_resp_val, 1'b0);
        check("byp_count", 32'(dut.count), 32'd0);
`else
        check("byp_next_val", proc_resp_val, 1'b1);
        check("byp_next_data", proc_resp_data, 32'hDEAD_BEEF);
`endif
        tick();
        mem_auto = 1'b1;
        drain();
        check("t6_resp_cnt", 32'(resp_cnt - base), 32'd1);

        // Streaming with random consumer stalls: exercises pointer wrap
        base = resp_cnt;
        sent = 0;
        for (int g = 0; g < 200 && sent < 8; g++) begin
            proc_req_val  = 1'b1;
            proc_req_addr = 32'h300 + 32'(4 * sent);
            proc_resp_rdy = 1'($urandom_range(0, 1));
            #1;
            if (proc_req_rdy) sent++;
            tick();
        end
        proc_req_val  = 1'b0;
        proc_resp_rdy = 1'b1;
        check("stream_sent", 32'(sent), 32'd8);
        drain();
        check("stream_resp_cnt", 32'(resp_cnt - base), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
